// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: debounced, conflict-safe pulse driver for a downstream clocked SR latch.
//
// Ports:
//   clk       in   single clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   set_req   in   raw asynchronous set request (button/switch)
//   clr_req   in   raw asynchronous clear request (button/switch)
//   C         out  latch enable, high only during the drive pulse
//   S_n       out  active-low set drive, low only during a SET pulse
//   R_n       out  active-low reset drive, low only during a CLR pulse
//   busy      out  high whenever the FSM is not in IDLE
//   conflict  out  one-cycle pulse when both requests are seen together
//   q_shadow  out  model of the downstream latch Q
//
// Optional feature: define SR_DRIVE_SHADOW_EN to build the q_shadow register;
// otherwise q_shadow is tied to 0.
module sr_drive_ctrl #(
    parameter int DB_CYCLES    = 4,
    parameter int PULSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic C,
    output logic S_n,
    output logic R_n,
    output logic busy,
    output logic conflict,
    output logic q_shadow
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PULSE, WAIT_REL} state_t;

    localparam logic [7:0] DB_LAST    = 8'(DB_CYCLES);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    state_t     state, nxt;
    logic [1:0] s_sync, c_sync;
    logic       ss, cs;
    logic [7:0] cnt, cnt_nxt;
    logic       dir, dir_nxt;
    logic       conf_nxt;
    logic       req_held;

    assign ss = s_sync[1];
    assign cs = c_sync[1];

    // Request being debounced, as selected by the recorded direction (1 = SET).
    assign req_held = dir ? ss : cs;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_sync <= 2'b00;
            c_sync <= 2'b00;
        end else begin
            s_sync <= {s_sync[0], set_req};
            c_sync <= {c_sync[0], clr_req};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            dir   <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        conf_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (ss && cs) begin
                    nxt      = WAIT_REL;
                    conf_nxt = 1'b1;
                end else if (ss || cs) begin
                    nxt     = DEBOUNCE;
                    dir_nxt = ss;
                    cnt_nxt = 8'd1;
                end
            end
            DEBOUNCE: begin
                if (ss && cs) begin
                    nxt      = WAIT_REL;
                    conf_nxt = 1'b1;
                    cnt_nxt  = 8'd0;
                end else if (req_held) begin
                    if (cnt >= DB_LAST) begin
                        nxt     = PULSE;
                        cnt_nxt = 8'd0;
                    end else begin
                        cnt_nxt = (cnt == 8'hff) ? cnt : cnt + 8'd1;
                    end
                end else begin
                    // Recorded request dropped: abandon this press without a pulse.
                    nxt     = IDLE;
                    cnt_nxt = 8'd0;
                end
            end
            PULSE: begin
                if (cnt >= PULSE_LAST) begin
                    nxt     = WAIT_REL;
                    cnt_nxt = 8'd0;
                end else begin
                    cnt_nxt = (cnt == 8'hff) ? cnt : cnt + 8'd1;
                end
            end
            WAIT_REL: nxt = (!ss && !cs) ? IDLE : WAIT_REL;
            default: begin
                nxt     = IDLE;
                cnt_nxt = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change only on clk
    // edges, and S_n/R_n are mutually exclusive by construction via dir.
    always_ff @(posedge clk) begin
        if (rst) begin
            C        <= 1'b0;
            S_n      <= 1'b1;
            R_n      <= 1'b1;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            C        <= (nxt == PULSE);
            S_n      <= !((nxt == PULSE) && dir_nxt);
            R_n      <= !((nxt == PULSE) && !dir_nxt);
            busy     <= (nxt != IDLE);
            conflict <= conf_nxt;
        end
    end

`ifdef SR_DRIVE_SHADOW_EN
    logic q_r;

    // Updated on the edge that enters PULSE, i.e. visible on the first pulse cycle.
    always_ff @(posedge clk) begin
        if (rst)
            q_r <= 1'b0;
        else if (nxt == PULSE && state != PULSE)
            q_r <= dir;
    end

    assign q_shadow = q_r;
`else
    assign q_shadow = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: scoreboard bench for sr_drive_ctrl against a run-length reference model.
module tb_sr_drive_ctrl;
    localparam int DB = 4;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst, set_req, clr_req;
    logic C, S_n, R_n, busy, conflict, q_shadow;

    sr_drive_ctrl #(.DB_CYCLES(DB), .PULSE_CYCLES(PL)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .C(C), .S_n(S_n), .R_n(R_n), .busy(busy), .conflict(conflict),
        .q_shadow(q_shadow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int typ;
        int cyc;
        bit dir;
    } ev_t;

    ev_t evq[$];

    int total = 0;
    int passed = 0;

    task automatic chk(string name, int act, int exp, int at);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, at, act, exp);
    endtask

    // Reference model: a press is accepted once the synchronised request has
    // been seen exclusively for DB+1 consecutive edges while the controller is
    // free; both-high while free is a conflict; after a pulse or conflict the
    // controller stays locked until both synchronised requests are low.
    bit hs[0:65535];
    bit hc[0:65535];
    int n_edges = 0;
    int last_rst = -1000;
    int pstart = -1000;
    bit pdir = 1'b0;
    bit locked = 1'b0;
    int run = 0;
    bit rdir = 1'b0;
    bit exp_q = 1'b0;

    always @(posedge clk) begin
        int k;
        bit sv, cv;
        k = n_edges;
        n_edges++;
        hs[k] = set_req;
        hc[k] = clr_req;
        if (rst) begin
            last_rst = k;
            run      = 0;
            locked   = 1'b0;
            pstart   = -1000;
            exp_q    = 1'b0;
        end else begin
            sv = (k - 2 > last_rst && k >= 2) ? hs[k-2] : 1'b0;
            cv = (k - 2 > last_rst && k >= 2) ? hc[k-2] : 1'b0;
            if (k > pstart && k <= pstart + PL) begin
                // pulse in progress: inputs ignored
            end else if (locked) begin
                if (!sv && !cv) locked = 1'b0;
            end else if (sv && cv) begin
                run    = 0;
                locked = 1'b1;
                evq.push_back('{typ: 1, cyc: k, dir: 1'b0});
            end else if (sv || cv) begin
                if (run == 0) begin
                    run  = 1;
                    rdir = sv;
                end else if (rdir == sv) begin
                    run++;
                end else begin
                    run = 0;
                end
                if (run == DB + 1) begin
                    pstart = k;
                    pdir   = rdir;
                    run    = 0;
                    locked = 1'b1;
                    evq.push_back('{typ: 2, cyc: k, dir: rdir});
`ifdef SR_DRIVE_SHADOW_EN
                    exp_q = rdir;
`endif
                end
            end else begin
                run = 0;
            end
        end
    end

    // Monitor: compares outputs every cycle on the falling edge and pops the
    // scoreboard whenever the DUT presents a conflict or a pulse start.
    logic c_prev = 1'b0;

    always @(negedge clk) begin
        int k;
        bit ec;
        ev_t e;
        if (n_edges > 0) begin
            k  = n_edges - 1;
            ec = (k >= pstart) && (k < pstart + PL);
            chk("drive", int'({C, S_n, R_n}),
                int'({ec, !(ec && pdir), !(ec && !pdir)}), k);
            chk("busy", int'(busy), int'(locked || run > 0), k);
            chk("q_shadow", int'(q_shadow), int'(exp_q), k);
            if (rst) chk("conflict_rst", int'(conflict), 0, k);
            if (conflict === 1'b1 || (C === 1'b1 && !c_prev)) begin
                if (evq.size() == 0) begin
                    chk("unexpected_event", conflict ? 1 : 2, 0, k);
                end else begin
                    e = evq.pop_front();
                    chk("event_type", conflict ? 1 : 2, e.typ, k);
                    chk("event_cycle", k, e.cyc, k);
                    if (e.typ == 2) chk("event_dir", int'(!S_n), int'(e.dir), k);
                end
            end else if (evq.size() > 0 && evq[0].cyc < k) begin
                e = evq.pop_front();
                chk("missed_event", -1, e.cyc, k);
            end
            c_prev = C;
        end
    end

    task automatic drive(bit s, bit c, bit r, int n);
        for (int i = 0; i < n; i++) begin
            set_req = s;
            clr_req = c;
            rst     = r;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 1, 2);
        drive(0, 0, 0, 4);
        // long SET press: single pulse
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 6);
        // short bounce: no pulse
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 8);
        // simultaneous press: conflict, locked until both released
        drive(1, 1, 0, 10);
        drive(0, 1, 0, 5);
        drive(0, 0, 0, 6);
        // CLR press interrupted by reset mid-pulse, held through reset
        drive(0, 1, 0, 6);
        drive(0, 1, 1, 1);
        drive(0, 1, 0, 15);
        drive(0, 0, 0, 6);
        // SET then CLR press for the latch shadow
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 5);
        drive(0, 1, 0, 10);
        drive(0, 0, 0, 5);
        // DEBOUNCE switching direction
        drive(1, 0, 0, 3);
        drive(0, 1, 0, 12);
        drive(0, 0, 0, 5);
        // randomized segments with occasional reset
        for (int i = 0; i < 900; i++) begin
            int p;
            p = int'($urandom_range(0, 9));
            if ($urandom_range(0, 39) == 0)
                drive(p[0], p[1], 1, int'($urandom_range(1, 2)));
            else if (p < 3)
                drive(0, 0, 0, int'($urandom_range(1, 10)));
            else if (p < 6)
                drive(1, 0, 0, int'($urandom_range(1, 12)));
            else if (p < 9)
                drive(0, 1, 0, int'($urandom_range(1, 12)));
            else
                drive(1, 1, 0, int'($urandom_range(1, 4)));
        end
        drive(0, 0, 0, 20);
        @(negedge clk);
        chk("leftover_events", evq.size(), 0, n_edges);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4, consecutive stable cycles required to accept a request (legal 1..255).
REQ-002 Parameter PULSE_CYCLES, default 2, length of the drive pulse in cycles (legal 1..255).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 set_req  in  1  asynchronous raw set request (button/switch).
REQ-006 clr_req  in  1  asynchronous raw clear request (button/switch).
REQ-007 C  out  1  latch enable for the downstream clocked SR latch, active-high.
REQ-008 S_n  out  1  active-low set drive to the downstream latch.
REQ-009 R_n  out  1  active-low reset drive to the downstream latch.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 conflict  out  1  one-cycle pulse when both requests are seen together.
REQ-012 q_shadow  out  1  model of the downstream latch Q (see Configuration).

Function
REQ-013 set_req and clr_req SHALL each pass through a 2-flop synchronizer; only synchronized values (ss, cs) drive the FSM.
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, PULSE, WAIT_REL.
REQ-015 IDLE: exactly one of ss/cs high -> DEBOUNCE, record direction (SET or CLR), counter=1; both high -> WAIT_REL with conflict=1; neither -> stay.
REQ-016 DEBOUNCE: recorded request still high and other low -> counter+1; counter==DB_CYCLES -> PULSE, counter cleared.
REQ-017 DEBOUNCE: recorded request low and other low -> IDLE, no pulse; both high -> WAIT_REL with conflict=1.
REQ-018 PULSE: C=1 and S_n=0 (SET) or R_n=0 (CLR) for exactly PULSE_CYCLES cycles, then WAIT_REL; input changes during PULSE are ignored.
REQ-019 WAIT_REL: outputs idle; both ss and cs low -> IDLE; otherwise stay (one accept per press).
REQ-020 Outside PULSE, outputs SHALL be C=0, S_n=1, R_n=1.
REQ-021 S_n=0 and R_n=0 SHALL never occur in the same cycle (forbidden latch input).
REQ-022 First pulse cycle SHALL be registered-output cycle 2+DB_CYCLES after the edge at which the raw request is first sampled high, given stable input.
REQ-023 Counters SHALL saturate, never wrap; all outputs registered, glitch-free.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, clear counters and synchronizers, and set C=0, S_n=1, R_n=1, busy=0, conflict=0, q_shadow=0.
REQ-025 rst asserted mid-PULSE SHALL terminate the pulse on that same edge; no partial pulse resumes after release.
REQ-026 After rst deasserts, a request held high through reset SHALL be treated as a fresh press (full sync + debounce latency).

Configuration
REQ-027 Macro SR_DRIVE_SHADOW_EN: when defined, q_shadow SHALL become 1 on the first SET pulse cycle and 0 on the first CLR pulse cycle, otherwise hold.
REQ-028 Without SR_DRIVE_SHADOW_EN, q_shadow SHALL be constant 0 and no shadow register SHALL be synthesized; all other behaviour identical.

Verification
REQ-029 DB=4,PULSE=2: set_req high from edge 0, held 20 cycles -> S_n=0,C=1 exactly at cycles 6-7, R_n=1 throughout, single pulse only.
REQ-030 set_req high for 3 cycles then low (bounce) -> no pulse, busy returns 0, outputs stay C=0,S_n=1,R_n=1.
REQ-031 set_req and clr_req raised on the same edge -> conflict=1 for one cycle at cycle 2, no pulse, busy until both low.
REQ-032 rst asserted at cycle 6 of a CLR press -> R_n=1,C=0 at that edge; no pulse after rst drops until clr_req is re-pressed past debounce.
REQ-033 SR_DRIVE_SHADOW_EN defined: SET press then CLR press -> q_shadow 0->1 at SET pulse, 1->0 at CLR pulse; undefined -> q_shadow stays 0.
REQ-034 Random-stimulus assertion over 10k cycles: never S_n=0 with R_n=0, never C=1 outside a pulse.
